// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with auto-incrementing byte register file
// Optional majority glitch filter on SCL/SDA: define I2C_TGT_GLITCH_FILTER_EN.
module i2c_target_regfile #(
  parameter logic [6:0] TgtAddr    = 7'h50,
  parameter int         NumRegs    = 16,
  parameter int         SyncStages = 2,
  localparam int        IdxW       = $clog2(NumRegs)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            scl_i,
  input  logic            sda_i,
  output logic            sda_o,
  output logic            sda_en_o,
  output logic            busy_o,
  output logic            wr_valid_o,
  output logic [IdxW-1:0] wr_idx_o,
  output logic [7:0]      wr_data_o,
  input  logic [IdxW-1:0] loc_idx_i,
  output logic [7:0]      loc_rdata_o
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK  = 3'd2;
  localparam logic [2:0] ST_WR_DATA   = 3'd3;
  localparam logic [2:0] ST_WR_ACK    = 3'd4;
  localparam logic [2:0] ST_RD_DATA   = 3'd5;
  localparam logic [2:0] ST_RD_ACK    = 3'd6;
  localparam logic [2:0] ST_WAIT_STOP = 3'd7;

  localparam logic [IdxW-1:0] PtrOne = 1;

  // Synchronizers reset to 1 so an idle bus produces no spurious edges
  logic [SyncStages-1:0] scl_sync, sda_sync;
  logic scl_raw, sda_raw, scl_s, sda_s;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SyncStages-2:0], scl_i};
      sda_sync <= {sda_sync[SyncStages-2:0], sda_i};
    end
  end

  assign scl_raw = scl_sync[SyncStages-1];
  assign sda_raw = sda_sync[SyncStages-1];

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_s    <= 1'b1;
      sda_s    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_raw};
      sda_hist <= {sda_hist[0], sda_raw};
      scl_s    <= (scl_raw & scl_hist[0]) | (scl_raw & scl_hist[1]) | (scl_hist[0] & scl_hist[1]);
      sda_s    <= (sda_raw & sda_hist[0]) | (sda_raw & sda_hist[1]) | (sda_hist[0] & sda_hist[1]);
    end
  end
`else
  assign scl_s = scl_raw;
  assign sda_s = sda_raw;
`endif

  // SDA moving while SCL is high in both samples is a bus condition; a
  // simultaneous SCL rise is treated as data.
  logic scl_q, sda_q;
  logic scl_rise_r, scl_fall_r, start_r, stop_r, sda_bit_r;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      scl_rise_r <= 1'b0;
      scl_fall_r <= 1'b0;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
      sda_bit_r  <= 1'b1;
    end else begin
      scl_q      <= scl_s;
      sda_q      <= sda_s;
      scl_rise_r <= scl_s & ~scl_q;
      scl_fall_r <= ~scl_s & scl_q;
      start_r    <= scl_s & scl_q & sda_q & ~sda_s;
      stop_r     <= scl_s & scl_q & ~sda_q & sda_s;
      sda_bit_r  <= sda_s;
    end
  end

  logic [2:0]      state;
  logic [3:0]      bit_cnt;
  logic [7:0]      shreg;
  logic [IdxW-1:0] ptr;
  logic            rw;
  logic            first;
  logic [7:0]      regs [NumRegs];
  logic [7:0]      rd_byte;

  assign rd_byte     = regs[ptr];
  assign loc_rdata_o = regs[loc_idx_i];
  assign sda_o       = 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= '0;
      rw         <= 1'b0;
      first      <= 1'b0;
      sda_en_o   <= 1'b0;
      busy_o     <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_idx_o   <= '0;
      wr_data_o  <= '0;
      for (int i = 0; i < NumRegs; i++) regs[i] <= '0;
    end else begin
      wr_valid_o <= 1'b0;
      if (start_r) begin
        state    <= ST_ADDR;
        bit_cnt  <= '0;
        busy_o   <= 1'b1;
        sda_en_o <= 1'b0;
      end else if (stop_r) begin
        state    <= ST_IDLE;
        bit_cnt  <= '0;
        busy_o   <= 1'b0;
        sda_en_o <= 1'b0;
      end else if (scl_rise_r) begin
        case (state)
          ST_ADDR, ST_WR_DATA: begin
            if (bit_cnt != 4'd8) begin
              shreg   <= {shreg[6:0], sda_bit_r};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          ST_RD_ACK: if (sda_bit_r) state <= ST_WAIT_STOP;
          default: ;
        endcase
      end else if (scl_fall_r) begin
        case (state)
          ST_ADDR: begin
            if (bit_cnt == 4'd8) begin
              if (shreg[7:1] == TgtAddr) begin
                state    <= ST_ADDR_ACK;
                sda_en_o <= 1'b1;
                rw       <= shreg[0];
              end else begin
                state <= ST_WAIT_STOP;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (rw) begin
              state    <= ST_RD_DATA;
              shreg    <= rd_byte;
              sda_en_o <= ~rd_byte[7];
              bit_cnt  <= 4'd1;
            end else begin
              state    <= ST_WR_DATA;
              sda_en_o <= 1'b0;
              first    <= 1'b1;
              bit_cnt  <= '0;
            end
          end
          ST_WR_DATA: begin
            if (bit_cnt == 4'd8) begin
              state    <= ST_WR_ACK;
              sda_en_o <= 1'b1;
              bit_cnt  <= '0;
              if (first) begin
                ptr   <= shreg[IdxW-1:0];
                first <= 1'b0;
              end else begin
                regs[ptr]  <= shreg;
                wr_valid_o <= 1'b1;
                wr_idx_o   <= ptr;
                wr_data_o  <= shreg;
                ptr        <= ptr + PtrOne;
              end
            end
          end
          ST_WR_ACK: begin
            state    <= ST_WR_DATA;
            sda_en_o <= 1'b0;
          end
          ST_RD_DATA: begin
            if (bit_cnt == 4'd8) begin
              state    <= ST_RD_ACK;
              sda_en_o <= 1'b0;
              ptr      <= ptr + PtrOne;
            end else begin
              shreg    <= {shreg[6:0], 1'b0};
              sda_en_o <= ~shreg[6];
              bit_cnt  <= bit_cnt + 4'd1;
            end
          end
          // Only reachable after a host ACK; a NACK already left on the rise
          ST_RD_ACK: begin
            state    <= ST_RD_DATA;
            shreg    <= rd_byte;
            sda_en_o <= ~rd_byte[7];
            bit_cnt  <= 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - directed self-checking bench for i2c_target_regfile
module tb_i2c_target_regfile;

  localparam int S = 2;
  localparam int Q = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       scl_i = 1'b1;
  logic       host_sda = 1'b1;
  logic       sda_i;
  logic       sda_o;
  logic       sda_en_o;
  logic       busy_o;
  logic       wr_valid_o;
  logic [3:0] wr_idx_o;
  logic [7:0] wr_data_o;
  logic [3:0] loc_idx_i = 4'd0;
  logic [7:0] loc_rdata_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] wq_idx [$];
  logic [7:0] wq_data[$];
  logic       prev_wv = 1'b0;
  int         consec = 0;
  logic       en_seen = 1'b0;

  assign sda_i = host_sda & ~sda_en_o;

  always #5 clk_i = ~clk_i;

  i2c_target_regfile #(
    .TgtAddr(7'h50), .NumRegs(16), .SyncStages(S)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .scl_i(scl_i), .sda_i(sda_i),
    .sda_o(sda_o), .sda_en_o(sda_en_o), .busy_o(busy_o),
    .wr_valid_o(wr_valid_o), .wr_idx_o(wr_idx_o), .wr_data_o(wr_data_o),
    .loc_idx_i(loc_idx_i), .loc_rdata_o(loc_rdata_o)
  );

  always @(negedge clk_i) begin
    if (wr_valid_o) begin
      wq_idx.push_back(wr_idx_o);
      wq_data.push_back(wr_data_o);
      if (prev_wv) consec++;
    end
    prev_wv = wr_valid_o;
    if (sda_en_o) en_seen = 1'b1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic i2c_start();
    host_sda = 1'b1; wait_clks(Q);
    scl_i = 1'b1;    wait_clks(Q);
    host_sda = 1'b0; wait_clks(Q);
    scl_i = 1'b0;    wait_clks(Q);
  endtask

  task automatic i2c_stop();
    host_sda = 1'b0; wait_clks(Q);
    scl_i = 1'b1;    wait_clks(Q);
    host_sda = 1'b1; wait_clks(Q);
  endtask

  task automatic send_bit(input logic b);
    host_sda = b;  wait_clks(Q);
    scl_i = 1'b1;  wait_clks(2 * Q);
    scl_i = 1'b0;  wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    host_sda = 1'b1; wait_clks(Q);
    scl_i = 1'b1;    wait_clks(Q);
    ack = ~sda_i;    wait_clks(Q);
    scl_i = 1'b0;    wait_clks(Q);
  endtask

  task automatic read_byte(input logic host_ack_bit, output logic [7:0] d, output logic en_ack);
    host_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clks(Q);
      scl_i = 1'b1; wait_clks(Q);
      d[i] = sda_i; wait_clks(Q);
      scl_i = 1'b0;
    end
    wait_clks(Q);
    host_sda = host_ack_bit; wait_clks(Q);
    scl_i = 1'b1;            wait_clks(Q);
    en_ack = sda_en_o;       wait_clks(Q);
    scl_i = 1'b0;            wait_clks(Q);
  endtask

  task automatic clear_mon();
    wq_idx.delete();
    wq_data.delete();
    en_seen = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    wait_clks(3);
    n_cmp++; if (sda_en_o !== 1'b0) begin n_err++; $display("FAIL reset_sda_en got %b want 0", sda_en_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (wr_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_wr_valid got %b want 0", wr_valid_o); end
    n_cmp++; if ({wr_idx_o, wr_data_o} !== 12'h000) begin n_err++; $display("FAIL reset_wr_bus got %h want 000", {wr_idx_o, wr_data_o}); end
    n_cmp++; if (loc_rdata_o !== 8'h00) begin n_err++; $display("FAIL reset_loc_rdata got %h want 00", loc_rdata_o); end
    n_cmp++; if (sda_o !== 1'b0) begin n_err++; $display("FAIL reset_sda_o got %b want 0", sda_o); end
    rst_ni = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_write_burst();
    logic a0, a1, a2, a3;
    clear_mon();
    i2c_start();
    send_byte(8'hA0, a0);
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL wb_busy got %b want 1", busy_o); end
    send_byte(8'h03, a1);
    send_byte(8'hA5, a2);
    send_byte(8'h5A, a3);
    i2c_stop();
    wait_clks(8);
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_err++; $display("FAIL wb_acks got %b want 1111", {a0, a1, a2, a3}); end
    n_cmp++; if (wq_idx.size() !== 2) begin n_err++; $display("FAIL wb_count got %0d want 2", wq_idx.size()); end
    if (wq_idx.size() == 2) begin
      n_cmp++; if ({wq_idx[0], wq_data[0]} !== 12'h3A5) begin n_err++; $display("FAIL wb_first got %h want 3a5", {wq_idx[0], wq_data[0]}); end
      n_cmp++; if ({wq_idx[1], wq_data[1]} !== 12'h45A) begin n_err++; $display("FAIL wb_second got %h want 45a", {wq_idx[1], wq_data[1]}); end
    end
    loc_idx_i = 4'd4; #1;
    n_cmp++; if (loc_rdata_o !== 8'h5A) begin n_err++; $display("FAIL wb_loc4 got %h want 5a", loc_rdata_o); end
    loc_idx_i = 4'd3; #1;
    n_cmp++; if (loc_rdata_o !== 8'hA5) begin n_err++; $display("FAIL wb_loc3 got %h want a5", loc_rdata_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL wb_busy_end got %b want 0", busy_o); end
  endtask

  task automatic test_read_repeated_start();
    logic a0, a1, a2, en0, en1;
    logic [7:0] d0, d1;
    clear_mon();
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h03, a1);
    i2c_start();
    send_byte(8'hA1, a2);
    read_byte(1'b0, d0, en0);
    read_byte(1'b1, d1, en1);
    i2c_stop();
    wait_clks(8);
    n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_err++; $display("FAIL rd_acks got %b want 111", {a0, a1, a2}); end
    n_cmp++; if (d0 !== 8'hA5) begin n_err++; $display("FAIL rd_byte0 got %h want a5", d0); end
    n_cmp++; if (d1 !== 8'h5A) begin n_err++; $display("FAIL rd_byte1 got %h want 5a", d1); end
    n_cmp++; if (en1 !== 1'b0) begin n_err++; $display("FAIL rd_nack_released got %b want 0", en1); end
    n_cmp++; if (wq_idx.size() !== 0) begin n_err++; $display("FAIL rd_no_writes got %0d want 0", wq_idx.size()); end
    n_cmp++; if ({busy_o, sda_en_o} !== 2'b00) begin n_err++; $display("FAIL rd_idle got %b want 00", {busy_o, sda_en_o}); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    clear_mon();
    i2c_start();
    send_byte(8'hA2, a0);
    send_byte(8'hFF, a1);
    n_cmp++; if ({a0, a1} !== 2'b00) begin n_err++; $display("FAIL wa_acks got %b want 00", {a0, a1}); end
    n_cmp++; if (en_seen !== 1'b0) begin n_err++; $display("FAIL wa_sda_en got %b want 0", en_seen); end
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL wa_busy got %b want 1", busy_o); end
    i2c_stop();
    wait_clks(8);
    n_cmp++; if (wq_idx.size() !== 0) begin n_err++; $display("FAIL wa_no_writes got %0d want 0", wq_idx.size()); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL wa_busy_end got %b want 0", busy_o); end
  endtask

  task automatic test_ptr_wrap();
    logic a0, a1, a2, a3;
    clear_mon();
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h0F, a1);
    send_byte(8'h11, a2);
    send_byte(8'h22, a3);
    i2c_stop();
    wait_clks(8);
    n_cmp++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_err++; $display("FAIL wrap_acks got %b want 1111", {a0, a1, a2, a3}); end
    n_cmp++; if (wq_idx.size() !== 2) begin n_err++; $display("FAIL wrap_count got %0d want 2", wq_idx.size()); end
    if (wq_idx.size() == 2) begin
      n_cmp++; if ({wq_idx[0], wq_data[0]} !== 12'hF11) begin n_err++; $display("FAIL wrap_first got %h want f11", {wq_idx[0], wq_data[0]}); end
      n_cmp++; if ({wq_idx[1], wq_data[1]} !== 12'h022) begin n_err++; $display("FAIL wrap_second got %h want 022", {wq_idx[1], wq_data[1]}); end
    end
    loc_idx_i = 4'd15; #1;
    n_cmp++; if (loc_rdata_o !== 8'h11) begin n_err++; $display("FAIL wrap_loc15 got %h want 11", loc_rdata_o); end
    loc_idx_i = 4'd0; #1;
    n_cmp++; if (loc_rdata_o !== 8'h22) begin n_err++; $display("FAIL wrap_loc0 got %h want 22", loc_rdata_o); end
  endtask

  task automatic test_partial_stop();
    logic a0, a1;
    clear_mon();
    i2c_start();
    send_byte(8'hA0, a0);
    send_byte(8'h00, a1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    host_sda = 1'b0; wait_clks(Q);
    scl_i = 1'b1;    wait_clks(Q);
    host_sda = 1'b1;
    wait_clks(S + 1);
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL ps_busy_before got %b want 1", busy_o); end
    wait_clks(1);
    n_cmp++; if ({busy_o, sda_en_o} !== 2'b00) begin n_err++; $display("FAIL ps_released got %b want 00", {busy_o, sda_en_o}); end
    wait_clks(8);
    n_cmp++; if (wq_idx.size() !== 0) begin n_err++; $display("FAIL ps_no_write got %0d want 0", wq_idx.size()); end
    loc_idx_i = 4'd0; #1;
    n_cmp++; if (loc_rdata_o !== 8'h22) begin n_err++; $display("FAIL ps_reg0 got %h want 22", loc_rdata_o); end
  endtask

  task automatic test_async_reset();
    logic [7:0] addr;
    addr = 8'hA0;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(addr[i]);
    n_cmp++; if (sda_en_o !== 1'b1) begin n_err++; $display("FAIL ar_ack_driven got %b want 1", sda_en_o); end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (sda_en_o !== 1'b0) begin n_err++; $display("FAIL ar_async_release got %b want 0", sda_en_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL ar_busy got %b want 0", busy_o); end
    for (int i = 0; i < 16; i++) begin
      loc_idx_i = 4'(i); #1;
      n_cmp++; if (loc_rdata_o !== 8'h00) begin n_err++; $display("FAIL ar_reg%0d got %h want 00", i, loc_rdata_o); end
    end
    scl_i = 1'b1;
    host_sda = 1'b1;
    wait_clks(4);
    rst_ni = 1'b1;
    wait_clks(4);
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_repeated_start();
    test_wrong_addr();
    test_ptr_wrap();
    test_partial_stop();
    n_cmp++; if (consec !== 0) begin n_err++; $display("FAIL wr_valid_consecutive got %0d want 0", consec); end
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
